// File: rtl/block_mem_responder.sv
// Block-transfer front end for a word-wide SRAM: moves one block of pixel words
// per request, one SRAM access per cycle, and collects read words into read_data.
module block_mem_responder #(
  parameter int ADDR_SIZE_BITS  = 24,
  parameter int WORD_SIZE_BYTES = 3,
  parameter int DATA_SIZE_WORDS = 64
) (
  input  logic                                           clk,
  input  logic                                           n_rst,
  input  logic                                           read_enable,
  input  logic                                           write_enable,
  input  logic [ADDR_SIZE_BITS-1:0]                      address,
  input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0]   write_data,
  output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0]   read_data,
  output logic                                           busy,
  output logic                                           data_ready,
  output logic [ADDR_SIZE_BITS-1:0]                      sram_addr,
  output logic [WORD_SIZE_BYTES*8-1:0]                   sram_wdata,
  input  logic [WORD_SIZE_BYTES*8-1:0]                   sram_rdata,
  output logic                                           sram_we,
  output logic                                           sram_re
);

  localparam int WORD_W = WORD_SIZE_BYTES * 8;
  localparam int CNT_W  = $clog2(DATA_SIZE_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_SIZE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_LAST, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg;
  logic [ADDR_SIZE_BITS-1:0] base_reg;
  logic [ADDR_SIZE_BITS-1:0] addr_hold_reg;
  logic [WORD_W-1:0]         wdata_hold_reg;
  logic [ADDR_SIZE_BITS-1:0] cur_addr;
  logic [WORD_W-1:0]         wbuf_reg    [DATA_SIZE_WORDS];
  logic [WORD_W-1:0]         rbuf_reg    [DATA_SIZE_WORDS];
  logic [WORD_W-1:0]         write_words [DATA_SIZE_WORDS];

  generate
    for (genvar gi = 0; gi < DATA_SIZE_WORDS; gi++) begin : g_words
      assign write_words[gi]                  = write_data[gi*WORD_W +: WORD_W];
      assign read_data[gi*WORD_W +: WORD_W]   = rbuf_reg[gi];
    end
  endgenerate

  // Address wraps naturally at the port width.
  assign cur_addr = base_reg + ADDR_SIZE_BITS'(cnt_reg);

  always_comb begin
    state_next = state_reg;
    sram_we    = 1'b0;
    sram_re    = 1'b0;
    sram_addr  = addr_hold_reg;
    sram_wdata = wdata_hold_reg;
    busy       = (state_reg != IDLE);
    data_ready = (state_reg == DONE);
    case (state_reg)
      IDLE: begin
        if (write_enable)     state_next = WRITE;
        else if (read_enable) state_next = READ;
      end
      WRITE: begin
        sram_we    = 1'b1;
        sram_addr  = cur_addr;
        sram_wdata = wbuf_reg[cnt_reg];
        if (cnt_reg == LAST_CNT) state_next = DONE;
      end
      READ: begin
        sram_re   = 1'b1;
        sram_addr = cur_addr;
        if (cnt_reg == LAST_CNT) state_next = READ_LAST;
      end
      READ_LAST: state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      base_reg       <= '0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
      for (int i = 0; i < DATA_SIZE_WORDS; i++) begin
        wbuf_reg[i] <= '0;
        rbuf_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (write_enable) begin
            base_reg <= address;
            cnt_reg  <= '0;
            for (int i = 0; i < DATA_SIZE_WORDS; i++) wbuf_reg[i] <= write_words[i];
          end else if (read_enable) begin
            base_reg <= address;
            cnt_reg  <= '0;
          end
        end
        WRITE: begin
          addr_hold_reg  <= cur_addr;
          wdata_hold_reg <= wbuf_reg[cnt_reg];
          cnt_reg        <= cnt_reg + CNT_W'(1);
        end
        READ: begin
          // SRAM returns data one cycle late, so this cycle's word belongs to cnt-1.
          addr_hold_reg <= cur_addr;
          if (cnt_reg != '0) rbuf_reg[cnt_reg - CNT_W'(1)] <= sram_rdata;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        READ_LAST: rbuf_reg[LAST_CNT] <= sram_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: block write, block read, address wrap,
// request arbitration, back-to-back acceptance and reset abort.
module tb_block_mem_responder;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          read_enable;
  logic          write_enable;
  logic [23:0]   address;
  logic [1535:0] write_data;
  logic [1535:0] read_data;
  logic          busy;
  logic          data_ready;
  logic [23:0]   sram_addr;
  logic [23:0]   sram_wdata;
  logic [23:0]   sram_rdata;
  logic          sram_we;
  logic          sram_re;

  int checks = 0;
  int errors = 0;
  logic [1535:0] exp_read_data = '0;

  block_mem_responder dut (
    .clk(clk), .n_rst(n_rst), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data), .busy(busy),
    .data_ready(data_ready), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_we(sram_we), .sram_re(sram_re)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, contents = address XOR constant.
  always @(posedge clk) begin
    if (sram_re) sram_rdata <= sram_addr ^ 24'hABCDEF;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
    address = '0; write_data = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got %b expected 0", data_ready); end
    checks++; if (sram_we !== 1'b0 || sram_re !== 1'b0) begin errors++; $display("FAIL reset_strobes got we=%b re=%b expected 0", sram_we, sram_re); end
    checks++; if (sram_addr !== 24'h0 || sram_wdata !== 24'h0) begin errors++; $display("FAIL reset_sram_bus got addr=%h wdata=%h expected 0", sram_addr, sram_wdata); end
    checks++; if (read_data !== '0) begin errors++; $display("FAIL reset_read_data got nonzero expected 0"); end
    n_rst = 1'b1;
  endtask

  task automatic run_write(input string name, input logic [23:0] base);
    logic [23:0] ea;
    for (int i = 0; i < 64; i++) write_data[i*24 +: 24] = 24'(i + 1);
    address = base; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      ea = base + 24'(c - 1);
      checks++;
      if (sram_we !== 1'b1 || sram_re !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL %s_ctrl cycle %0d got we=%b re=%b dr=%b busy=%b expected 1 0 0 1", name, c, sram_we, sram_re, data_ready, busy);
      end
      checks++;
      if (sram_addr !== ea || sram_wdata !== 24'(c)) begin
        errors++; $display("FAIL %s_bus cycle %0d got addr=%h wdata=%h expected addr=%h wdata=%h", name, c, sram_addr, sram_wdata, ea, 24'(c));
      end
      step();
    end
    ea = base + 24'd63;
    checks++;
    if (data_ready !== 1'b1 || sram_we !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_done cycle 65 got dr=%b we=%b busy=%b expected 1 0 1", name, data_ready, sram_we, busy);
    end
    checks++;
    if (sram_addr !== ea || sram_wdata !== 24'd64) begin
      errors++; $display("FAIL %s_hold got addr=%h wdata=%h expected addr=%h wdata=%h", name, sram_addr, sram_wdata, ea, 24'd64);
    end
    step();
    checks++;
    if (busy !== 1'b0 || data_ready !== 1'b0) begin
      errors++; $display("FAIL %s_idle got busy=%b dr=%b expected 0 0", name, busy, data_ready);
    end
    checks++;
    if (read_data !== exp_read_data) begin
      errors++; $display("FAIL %s_read_data_held word0 got %h expected %h", name, read_data[23:0], exp_read_data[23:0]);
    end
  endtask

  task automatic run_read(input string name, input logic [23:0] base);
    logic [23:0] ea;
    address = base; read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      ea = base + 24'(c - 1);
      checks++;
      if (sram_re !== 1'b1 || sram_we !== 1'b0 || data_ready !== 1'b0 || sram_addr !== ea) begin
        errors++; $display("FAIL %s_strobe cycle %0d got re=%b we=%b dr=%b addr=%h expected 1 0 0 %h", name, c, sram_re, sram_we, data_ready, sram_addr, ea);
      end
      step();
    end
    checks++;
    if (sram_re !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_last cycle 65 got re=%b dr=%b busy=%b expected 0 0 1", name, sram_re, data_ready, busy);
    end
    step();
    checks++;
    if (data_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_done cycle 66 got dr=%b busy=%b expected 1 1", name, data_ready, busy);
    end
    for (int i = 0; i < 64; i++) exp_read_data[i*24 +: 24] = (base + 24'(i)) ^ 24'hABCDEF;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (read_data[i*24 +: 24] !== exp_read_data[i*24 +: 24]) begin
        errors++; $display("FAIL %s_word%0d got %h expected %h", name, i, read_data[i*24 +: 24], exp_read_data[i*24 +: 24]);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle got busy=%b expected 0", name, busy); end
  endtask

  task automatic test_simultaneous_and_busy();
    int we_n = 0, re_n = 0, dr_n = 0;
    for (int i = 0; i < 64; i++) write_data[i*24 +: 24] = 24'(i + 1);
    address = 24'h000400; read_enable = 1'b1; write_enable = 1'b1;
    step();
    read_enable = 1'b0; write_enable = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      read_enable = (c == 10);
      if (sram_we) we_n++;
      if (sram_re) re_n++;
      if (data_ready) dr_n++;
      step();
    end
    read_enable = 1'b0;
    checks++; if (we_n != 64) begin errors++; $display("FAIL both_we_cycles got %0d expected 64", we_n); end
    checks++; if (re_n != 0) begin errors++; $display("FAIL both_re_cycles got %0d expected 0", re_n); end
    checks++; if (dr_n != 1) begin errors++; $display("FAIL both_data_ready_pulses got %0d expected 1", dr_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_idle got busy=%b expected 0", busy); end
    checks++; if (read_data !== exp_read_data) begin errors++; $display("FAIL both_read_data_held word0 got %h expected %h", read_data[23:0], exp_read_data[23:0]); end
  endtask

  task automatic test_back_to_back();
    address = 24'h000500; write_enable = 1'b1;
    step();
    for (int c = 1; c < 65; c++) step();
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL b2b_done cycle 65 got dr=%b expected 1", data_ready); end
    step();
    checks++; if (busy !== 1'b0 || sram_we !== 1'b0) begin errors++; $display("FAIL b2b_idle cycle 66 got busy=%b we=%b expected 0 0", busy, sram_we); end
    step();
    write_enable = 1'b0;
    checks++;
    if (sram_we !== 1'b1 || sram_addr !== 24'h000500) begin
      errors++; $display("FAIL b2b_reaccept cycle 67 got we=%b addr=%h expected 1 000500", sram_we, sram_addr);
    end
    for (int c = 0; c < 70; c++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_finish got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    address = 24'h000300; read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    for (int c = 1; c < 30; c++) step();
    checks++;
    if (sram_re !== 1'b1 || sram_addr !== 24'h00031D) begin
      errors++; $display("FAIL rst_mid_active cycle 30 got re=%b addr=%h expected 1 00031d", sram_re, sram_addr);
    end
    n_rst = 1'b0;
    step();
    checks++; if (sram_re !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got re=%b busy=%b dr=%b expected 0 0 0", sram_re, busy, data_ready); end
    checks++; if (read_data !== '0 || sram_addr !== 24'h0) begin errors++; $display("FAIL rst_mid_clear got word0=%h addr=%h expected 0 0", read_data[23:0], sram_addr); end
    n_rst = 1'b1;
    exp_read_data = '0;
    run_read("post_reset_read", 24'h000200);
  endtask

  initial begin
    test_reset();
    run_read("read", 24'h000200);
    run_write("write", 24'h000100);
    run_write("wrap", 24'hFFFFF0);
    test_simultaneous_and_busy();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_mem_responder.md
BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
REQ-001 The module SHALL have parameter ADDR_SIZE_BITS, default 24, giving the width of the block base address and the SRAM word address.
REQ-002 The module SHALL have parameter WORD_SIZE_BYTES, default 3, giving the bytes per pixel word.
REQ-003 The module SHALL have parameter DATA_SIZE_WORDS, default 64, giving the words per block transfer.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port n_rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 The module SHALL have port read_enable, input, 1 bit: block read request from the client.
REQ-007 The module SHALL have port write_enable, input, 1 bit: block write request from the client.
REQ-008 The module SHALL have port address, input, ADDR_SIZE_BITS: block base word address.
REQ-009 The module SHALL have port write_data, input, W = WORD_SIZE_BYTES*DATA_SIZE_WORDS*8 (1536) bits: block to write; word i occupies bits [24i+23:24i].
REQ-010 The module SHALL have port read_data, output, W bits: block read back; word i occupies bits [24i+23:24i].
REQ-011 The module SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-012 The module SHALL have port data_ready, output, 1 bit: one-cycle completion pulse.
REQ-013 The module SHALL have port sram_addr, output, ADDR_SIZE_BITS: SRAM word address.
REQ-014 The module SHALL have port sram_wdata, output, 24 bits: SRAM write word.
REQ-015 The module SHALL have port sram_rdata, input, 24 bits: SRAM read word, valid the cycle after sram_re.
REQ-016 The module SHALL have port sram_we, output, 1 bit: SRAM write strobe.
REQ-017 The module SHALL have port sram_re, output, 1 bit: SRAM read strobe.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, WRITE, READ, READ_LAST and DONE.
REQ-019 In IDLE with write_enable=1, the block SHALL latch address and write_data, clear the 6-bit word counter, and go to WRITE.
REQ-020 In IDLE with read_enable=1 and write_enable=0, the block SHALL latch address, clear the counter, and go to READ.
REQ-021 When read_enable and write_enable are both 1 in IDLE, the block SHALL perform the write only.
REQ-022 In WRITE, each cycle the block SHALL assert sram_we=1, drive sram_addr = base+cnt and sram_wdata = word cnt, then increment cnt.
REQ-023 The block SHALL leave WRITE for DONE after the cycle with cnt = 63, giving 64 write cycles.
REQ-024 In READ, each cycle the block SHALL assert sram_re=1 and drive sram_addr = base+cnt.
REQ-025 In READ, each cycle after the first the block SHALL store sram_rdata into read_data word cnt-1.
REQ-026 The block SHALL leave READ for READ_LAST after cnt = 63.
REQ-027 READ_LAST SHALL last one cycle, with sram_re=0, and SHALL store sram_rdata into word 63 before going to DONE.
REQ-028 DONE SHALL last one cycle with data_ready=1, then return to IDLE.
REQ-029 The block SHALL have the following latency, with the accept edge as cycle 0:
- write: sram_we high in cycles 1-64; data_ready high in cycle 65.
- read: sram_re high in cycles 1-64; data_ready high in cycle 66.
REQ-030 busy SHALL be 1 in every state except IDLE, including DONE.
REQ-031 Requests arriving while busy=1 SHALL be ignored, not queued.
REQ-032 A request held high through DONE SHALL be accepted again in the next IDLE cycle.
REQ-033 Address arithmetic SHALL be modulo 2^ADDR_SIZE_BITS, so base 24'hFFFFF0 wraps to 24'h000000 at cnt=16.
REQ-034 read_data SHALL change only while a read is in progress.
REQ-035 read_data SHALL hold its value from the last completed read through any later write or idle period.
REQ-036 sram_we and sram_re SHALL never both be 1 in the same cycle.
REQ-037 In IDLE and DONE, sram_we and sram_re SHALL be 0.
REQ-038 In IDLE and DONE, sram_addr and sram_wdata SHALL hold their last values.

Reset
REQ-039 On a clk edge with n_rst=0, the block SHALL reset: state to IDLE, counter, base and latched data to 0, and all outputs to 0 (busy, data_ready, sram_we, sram_re, sram_addr, sram_wdata, read_data).
REQ-040 A reset during any transfer SHALL abort it, with no strobe in the cycle after the reset edge and no data_ready pulse.
REQ-041 After release, the block SHALL accept a new request on the first clk edge with n_rst=1.

Verification
REQ-042 Write: address=24'h000100, word i = i+1, write_enable pulsed one cycle -> 64 sram_we cycles writing addresses 0x100-0x13F with data 1-64, then data_ready in cycle 65, then busy=0.
REQ-043 Read: SRAM model returns addr XOR 24'hABCDEF, read at address=0x000200 -> data_ready in cycle 66 and read_data word i = (0x200+i) XOR 0xABCDEF for all 64 words.
REQ-044 Wrap: write at base 24'hFFFFF0 -> sram_addr runs 0xFFFFF0-0xFFFFFF, then 0x000000-0x00002F.
REQ-045 Simultaneous and busy requests: read_enable and write_enable both 1 -> write only, with no sram_re; a read_enable pulse at cycle 10 of a write -> ignored, no extra transfer.
REQ-046 Reset mid-read: n_rst=0 at cycle 30 -> the next cycle has sram_re=0, busy=0, read_data=0, and no data_ready; the following read completes normally.
